// File: rtl/frame_write_arbiter_if.sv
// Port bundle for the frame buffer write arbiter: pixel stream, fill command and buffer write side.
// The slave modport is the arbiter; the master modport is whoever drives requests and watches the buffer.
interface frame_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [9:0]        s_x;
  logic [8:0]        s_y;
  logic [DATA_W-1:0] s_data;

  logic              fill_start;
  logic [9:0]        fill_x0;
  logic [9:0]        fill_x1;
  logic [8:0]        fill_y0;
  logic [8:0]        fill_y1;
  logic [DATA_W-1:0] fill_color;
  logic              fill_busy;
  logic              fill_done;
  logic              err_oob;

  logic [ADDR_W-1:0] wraddress;
  logic [DATA_W-1:0] write_data;
  logic              wren;

  modport slave (
    input  s_valid, s_x, s_y, s_data,
    input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output s_ready, fill_busy, fill_done, err_oob,
    output wraddress, write_data, wren
  );

  modport master (
    output s_valid, s_x, s_y, s_data,
    output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  s_ready, fill_busy, fill_done, err_oob,
    input  wraddress, write_data, wren
  );
endinterface

// File: rtl/frame_write_arbiter.sv
// Shares the single frame buffer write port between a pixel stream and a rectangle-fill engine.
// The stream has priority; a bounded stream run forces a fill slot so the fill always progresses.
//
// state | meaning
// IDLE  | no fill in flight, fill_start is sampled
// RUN   | fill in flight, granted whenever the stream does not take the port
// DONE  | one-cycle fill_done pulse, then back to IDLE
module frame_write_arbiter #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int ADDR_W         = 19,
  parameter int DATA_W         = 8,
  parameter int MAX_STREAM_RUN = 15
) (
  input  logic clk,
  input  logic reset_n,
  frame_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_STREAM_RUN + 1);
  localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(MAX_STREAM_RUN);
  localparam logic [9:0]        X_LAST  = 10'(H_RES - 1);
  localparam logic [8:0]        Y_LAST  = 9'(V_RES - 1);
  localparam logic [ADDR_W-1:0] LINE    = ADDR_W'(H_RES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]  run_cnt;
  logic [9:0]        x0_q, x1_q, cx;
  logic [8:0]        y1_q, cy;
  logic [ADDR_W-1:0] row_base;
  logic [DATA_W-1:0] color_q;

  logic              accept, in_range, fill_grant, load, last_pix, fill_empty, ready;
  logic [9:0]        x1_clamp;
  logic [8:0]        y1_clamp;
  logic [ADDR_W-1:0] s_addr, start_base;

  logic              wren_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  assign ready    = !(state == RUN && run_cnt == RUN_MAX);
  assign accept   = bus.s_valid && ready;
  assign in_range = (bus.s_x < 10'(H_RES)) && (bus.s_y < 9'(V_RES));
  assign s_addr   = ADDR_W'(bus.s_y) * LINE + ADDR_W'(bus.s_x);

  assign x1_clamp   = (bus.fill_x1 > X_LAST) ? X_LAST : bus.fill_x1;
  assign y1_clamp   = (bus.fill_y1 > Y_LAST) ? Y_LAST : bus.fill_y1;
  assign fill_empty = (bus.fill_x0 > x1_clamp) || (bus.fill_y0 > y1_clamp) ||
                      (bus.fill_x0 >= 10'(H_RES)) || (bus.fill_y0 >= 9'(V_RES));
  // The one multiply on the fill side happens once at load; stepping rows is an add.
  assign start_base = ADDR_W'(bus.fill_y0) * LINE;
  assign last_pix   = (cx == x1_q) && (cy == y1_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fill_grant = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fill_start) begin
          load     = 1'b1;
          state_nx = fill_empty ? DONE : RUN;
        end
      end
      RUN: begin
        if (!accept) begin
          fill_grant = 1'b1;
          if (last_pix) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      color_q  <= '0;
    end else if (load) begin
      x0_q     <= bus.fill_x0;
      x1_q     <= x1_clamp;
      y1_q     <= y1_clamp;
      cx       <= bus.fill_x0;
      cy       <= bus.fill_y0;
      row_base <= start_base;
      color_q  <= bus.fill_color;
    end else if (fill_grant) begin
      if (cx < x1_q) begin
        cx <= cx + 10'd1;
      end else begin
        cx       <= x0_q;
        cy       <= cy + 9'd1;
        row_base <= row_base + LINE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      run_cnt <= '0;
    else if (state != RUN || fill_grant) run_cnt <= '0;
    else if (accept && run_cnt != RUN_MAX) run_cnt <= run_cnt + CNT_W'(1);
  end

  // A dropped out-of-range pixel still completes its handshake but leaves the address/data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wren_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wren_q <= (accept && in_range) || fill_grant;
      err_q  <= accept && !in_range;
      if (accept && in_range) begin
        addr_q <= s_addr;
        data_q <= bus.s_data;
      end else if (fill_grant) begin
        addr_q <= row_base + ADDR_W'(cx);
        data_q <= color_q;
      end
    end
  end

  assign bus.s_ready    = ready;
  assign bus.fill_busy  = (state == RUN);
  assign bus.fill_done  = (state == DONE);
  assign bus.err_oob    = err_q;
  assign bus.wren       = wren_q;
  assign bus.wraddress  = addr_q;
  assign bus.write_data = data_q;
endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
- Owns the single write port of the 640x480x8 frame buffer and shares it between two requesters.
- Requester 1 is a pixel stream (camera/renderer) with (x,y) coordinates and a valid/ready handshake.
- Requester 2 is an internal rectangle-fill engine started by a command pulse.
- Converts coordinates to linear addresses, prioritises the stream and guarantees the fill engine forward progress; all buffer-side outputs are registered.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, buffer address width
- DATA_W, 8, pixel width
- MAX_STREAM_RUN, 15, consecutive stream grants allowed while a fill is pending before one fill slot is forced

Ports:
- clk  in  1  single clock; the buffer write clock is driven from this same clock
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  stream pixel valid
- s_ready  out  1  stream pixel accepted this cycle when s_valid&&s_ready
- s_x  in  10  stream pixel column
- s_y  in  9  stream pixel row
- s_data  in  DATA_W  stream pixel value
- fill_start  in  1  one-cycle fill command; sampled only when idle
- fill_x0, fill_x1  in  10  fill column bounds, inclusive
- fill_y0, fill_y1  in  9  fill row bounds, inclusive
- fill_color  in  DATA_W  fill pixel value
- fill_busy  out  1  high while the fill FSM is in RUN
- fill_done  out  1  one-cycle pulse when a fill completes
- err_oob  out  1  one-cycle pulse: a stream pixel was out of range and dropped
- wraddress  out  ADDR_W  buffer write address
- write_data  out  DATA_W  buffer write data
- wren  out  1  buffer write enable

Behaviour:
- Reset (asynchronous, reset_n=0):
  - wren, wraddress, write_data, fill_busy, fill_done, err_oob, run_cnt are all 0; FSM is IDLE.
  - s_ready is 1 from the first cycle after reset_n rises.
- s_ready is combinational: s_ready = !(state==RUN && run_cnt==MAX_STREAM_RUN).
- Latency: a stream accept or fill grant in cycle N produces wren=1 with the matching wraddress/write_data in cycle N+1. When nothing is granted in cycle N, wren=0 in N+1 and wraddress/write_data hold their values.
- Stream address: y*H_RES + x, truncated to ADDR_W bits.
- Out-of-range stream pixel (s_x>=H_RES or s_y>=V_RES) that is accepted:
  - The handshake completes, but no write occurs (wren=0 in N+1).
  - err_oob=1 in N+1.
  - It counts as a stream grant for run_cnt.
- Fill FSM has three states: IDLE, RUN, DONE.
  - IDLE: on fill_start, latch color and bounds.
    - Clamp x1 to min(x1,H_RES-1) and y1 to min(y1,V_RES-1).
    - If x0>x1 or y0>y1 after clamping, or x0>=H_RES, or y0>=V_RES: go to DONE with no writes.
    - Otherwise go to RUN with cursor (cx,cy)=(x0,y0) and row_base=y0*H_RES.
  - RUN: fill_busy=1. The fill is granted in any cycle where no stream pixel is accepted, i.e. !(s_valid&&s_ready).
    - A grant writes address row_base+cx with fill_color.
    - If cx<x1: cx++.
    - Else: cx=x0, cy++, row_base+=H_RES (incremental; no multiplier on the fill path).
    - The grant that writes (x1,y1) moves the FSM to DONE.
  - DONE: fill_done=1 for exactly one cycle, then IDLE. The final fill write's wren and fill_done occur in the same cycle.
- fill_start is ignored in RUN and DONE; the in-flight fill is never retargeted.
- Starvation guard:
  - run_cnt increments on each stream accept while in RUN.
  - run_cnt clears on a fill grant and whenever the state is not RUN; it saturates at MAX_STREAM_RUN.
  - With run_cnt==MAX_STREAM_RUN, s_ready=0 and the fill is granted that cycle.
  - The worst case is therefore 1 fill write per MAX_STREAM_RUN+1 cycles.
- Simultaneous events:
  - Stream accept and fill pending in the same cycle: the stream wins unless the guard is forcing a fill slot.
  - fill_start in the same cycle as a stream accept: the FSM enters RUN and the stream write proceeds normally.
- Reset mid-fill aborts the fill: no fill_done, and the FSM returns to IDLE.

Test Plan:
- Reset release, s_valid=1, (x,y)=(5,2), data=0xA5 -> s_ready=1; one cycle later wren=1, wraddress=1285, write_data=0xA5.
- Corner pixel (639,479), data=0x3C -> wraddress=307199. Then (640,0) -> accepted, wren=0, err_oob pulses once.
- No stream traffic; fill (10..12, 3..4), color=0x7F -> six writes at addresses 1930, 1931, 1932, 2570, 2571, 2572 on consecutive cycles. fill_busy is high for 6 cycles, and fill_done pulses in the same cycle as the 6th write.
- Continuous s_valid=1 during a 2x1 fill -> s_ready drops for exactly 1 cycle after every 15 stream accepts; the fill completes after 32 cycles; no stream pixel is lost (accept count matches the number of stream writes).
- Fill (100..50, 0..0), and separately a fill with x1=700 -> the first gives fill_done with zero writes; the second writes columns x0..639 only. fill_start during RUN -> ignored; bounds and write count are unchanged.
- reset_n pulsed low during RUN -> wren, fill_busy and fill_done drop to 0 immediately and no fill_done pulses. A new fill started after reset completes normally.
